mul_share_arb: RTL

MUL_SHARE_ARB -- requirements
Module: mul_share_arb

---
 rtl/mul_share_arb.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mul_share_arb.sv
// Two-requester arbiter around one shared 8x8 unsigned multiplier; MUL_SHARE_CNT_EN adds grant counters.
// Latency: accept in cycle T gives rsp valid in T+2; one product per 3 cycles at best.
// Backpressure: response held stable until the owner's rsp_ready; no new accept until back in IDLE.
module mul_share_arb (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [7:0]  req0_a,
    input  logic [7:0]  req0_b,
    output logic        req0_ready,
    output logic        rsp0_valid,
    output logic [15:0] rsp0_y,
    input  logic        rsp0_ready,
    input  logic        req1_valid,
    input  logic [7:0]  req1_a,
    input  logic [7:0]  req1_b,
    output logic        req1_ready,
    output logic        rsp1_valid,
    output logic [15:0] rsp1_y,
    input  logic        rsp1_ready
`ifdef MUL_SHARE_CNT_EN
    ,
    output logic [15:0] gnt0_cnt,
    output logic [15:0] gnt1_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        rr;
    logic        owner;
    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic [15:0] result;
    logic [15:0] prod;
    logic        both;
    logic        gnt;
    logic        accept;
    logic        own_rdy;

    assign both    = req0_valid & req1_valid;
    assign gnt     = both ? rr : req1_valid;
    assign accept  = (state == IDLE) && !rst && (req0_valid || req1_valid);
    assign own_rdy = owner ? rsp1_ready : rsp0_ready;

    // Shift-and-add over AND partial products; full 16-bit sum, no truncation.
    always_comb begin
        prod = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            prod = prod + (({8'h00, a_q & {8{b_q[i]}}}) << i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = accept ? MUL : IDLE;
            MUL:     state_nxt = RESP;
            RESP:    state_nxt = own_rdy ? IDLE : RESP;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        rsp0_y     = 16'h0000;
        rsp1_y     = 16'h0000;
        if (!rst) begin
            req0_ready = (state == IDLE) && req0_valid && !gnt;
            req1_ready = (state == IDLE) && req1_valid && gnt;
            rsp0_valid = (state == RESP) && !owner;
            rsp1_valid = (state == RESP) && owner;
            rsp0_y     = result;
            rsp1_y     = result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= 8'h00;
            b_q    <= 8'h00;
            owner  <= 1'b0;
            rr     <= 1'b0;
            result <= 16'h0000;
        end else begin
            if (accept) begin
                a_q   <= gnt ? req1_a : req0_a;
                b_q   <= gnt ? req1_b : req0_b;
                owner <= gnt;
                // A lone requester that already holds the pointer keeps it.
                if (both || (gnt != rr)) begin
                    rr <= ~gnt;
                end
            end
            if (state == MUL) begin
                result <= prod;
            end
        end
    end

`ifdef MUL_SHARE_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt0_cnt <= 16'h0000;
            gnt1_cnt <= 16'h0000;
        end else if (accept) begin
            if (gnt) begin
                gnt1_cnt <= gnt1_cnt + 16'h0001;
            end else begin
                gnt0_cnt <= gnt0_cnt + 16'h0001;
            end
        end
    end
`endif

endmodule
